// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one synchronous-read VRAM port between the VGA scan
// fetch path (absolute priority) and buffered MiniAlu CPU pixel writes.
// Build option: define VRAM_WRFIFO_EN to buffer writes in a FIFO_DEPTH-entry
// circular FIFO; leave it undefined for a single holding register.
module vram_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          iRdReq,
  input  logic [ADDR_W-1:0]             iRdAddr,
  output logic                          oRdValid,
  output logic [DATA_W-1:0]             oRdData,
  input  logic                          iWrValid,
  input  logic [ADDR_W-1:0]             iWrAddr,
  input  logic [DATA_W-1:0]             iWrData,
  output logic                          oWrReady,
  output logic [$clog2(FIFO_DEPTH):0]   oWrLevel,
  output logic [ADDR_W-1:0]             oRamAddr,
  output logic                          oRamWe,
  output logic [DATA_W-1:0]             oRamWData,
  input  logic [DATA_W-1:0]             iRamRData
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
`ifdef VRAM_WRFIFO_EN
  localparam int CAPACITY = FIFO_DEPTH;
`else
  localparam int CAPACITY = 1;
`endif

  logic [LVL_W-1:0]  levelReg;
  logic [LVL_W-1:0]  levelNext;
  logic              wrReadyReg;
  logic              bufEmpty;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] headAddr;
  logic [DATA_W-1:0] headData;

  logic [ADDR_W-1:0] ramAddrReg;
  logic              ramWeReg;
  logic [DATA_W-1:0] ramWDataReg;
  logic              rdIssuedReg;
  logic              rdValidReg;

  // Occupancy comes only from the registered level, so a fresh push is not
  // visible to the pop decision until the following cycle (no bypass).
  assign bufEmpty = (levelReg == '0);
  assign push     = iWrValid && wrReadyReg;
  assign pop      = !iRdReq && !bufEmpty;

  // Next occupancy: a simultaneous push and pop leave the level unchanged.
  always_comb begin
    levelNext = levelReg;
    if (push && !pop) begin
      levelNext = levelReg + LVL_W'(1);
    end else if (!push && pop) begin
      levelNext = levelReg - LVL_W'(1);
    end
  end

  // Level counter and registered ready flag (ready = not full next cycle).
  always_ff @(posedge Clock) begin
    if (Reset) begin
      levelReg   <= '0;
      wrReadyReg <= 1'b1;
    end else begin
      levelReg   <= levelNext;
      wrReadyReg <= (levelNext != LVL_W'(CAPACITY));
    end
  end

`ifdef VRAM_WRFIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [PTR_W-1:0]  wrPtrReg;
  logic [PTR_W-1:0]  rdPtrReg;
  logic [ADDR_W-1:0] addrMem [FIFO_DEPTH];
  logic [DATA_W-1:0] dataMem [FIFO_DEPTH];

  // Circular pointers wrap naturally at FIFO_DEPTH (a power of two).
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
    end else begin
      if (push) wrPtrReg <= wrPtrReg + PTR_W'(1);
      if (pop)  rdPtrReg <= rdPtrReg + PTR_W'(1);
    end
  end

  // Entry storage; stale contents after reset are harmless since level is 0.
  always_ff @(posedge Clock) begin
    if (push) begin
      addrMem[wrPtrReg] <= iWrAddr;
      dataMem[wrPtrReg] <= iWrData;
    end
  end

  assign headAddr = addrMem[rdPtrReg];
  assign headData = dataMem[rdPtrReg];
`else
  logic [ADDR_W-1:0] holdAddrReg;
  logic [DATA_W-1:0] holdDataReg;

  // Single holding register; push only happens while it is free.
  always_ff @(posedge Clock) begin
    if (push) begin
      holdAddrReg <= iWrAddr;
      holdDataReg <= iWrData;
    end
  end

  assign headAddr = holdAddrReg;
  assign headData = holdDataReg;
`endif

  // Port arbitration: scan read first, then the buffered write, else idle
  // with address/data held to avoid needless toggling on the RAM pins.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ramAddrReg  <= '0;
      ramWeReg    <= 1'b0;
      ramWDataReg <= '0;
    end else if (iRdReq) begin
      ramAddrReg  <= iRdAddr;
      ramWeReg    <= 1'b0;
    end else if (!bufEmpty) begin
      ramAddrReg  <= headAddr;
      ramWDataReg <= headData;
      ramWeReg    <= 1'b1;
    end else begin
      ramWeReg    <= 1'b0;
    end
  end

  // Read-valid pipeline: one stage for the address register, one for the RAM.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rdIssuedReg <= 1'b0;
      rdValidReg  <= 1'b0;
    end else begin
      rdIssuedReg <= iRdReq;
      rdValidReg  <= rdIssuedReg;
    end
  end

  assign oRdValid  = rdValidReg;
  assign oRdData   = iRamRData;
  assign oWrReady  = wrReadyReg;
  assign oWrLevel  = levelReg;
  assign oRamAddr  = ramAddrReg;
  assign oRamWe    = ramWeReg;
  assign oRamWData = ramWDataReg;

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: table of per-cycle vectors plus directed
// multi-cycle sequences (priority, full, hazard, reset during drain).
`timescale 1ns/1ps
module tb_vram_arbiter;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
`ifdef VRAM_WRFIFO_EN
  localparam int CAP = FIFO_DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic              Clock = 1'b0;
  logic              Reset = 1'b1;
  logic              iRdReq = 1'b0;
  logic [ADDR_W-1:0] iRdAddr = '0;
  logic              oRdValid;
  logic [DATA_W-1:0] oRdData;
  logic              iWrValid = 1'b0;
  logic [ADDR_W-1:0] iWrAddr = '0;
  logic [DATA_W-1:0] iWrData = '0;
  logic              oWrReady;
  logic [LVL_W-1:0]  oWrLevel;
  logic [ADDR_W-1:0] oRamAddr;
  logic              oRamWe;
  logic [DATA_W-1:0] oRamWData;
  logic [DATA_W-1:0] ramRData;

  int checks = 0;
  int errors = 0;

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .Clock(Clock), .Reset(Reset),
    .iRdReq(iRdReq), .iRdAddr(iRdAddr),
    .oRdValid(oRdValid), .oRdData(oRdData),
    .iWrValid(iWrValid), .iWrAddr(iWrAddr), .iWrData(iWrData),
    .oWrReady(oWrReady), .oWrLevel(oWrLevel),
    .oRamAddr(oRamAddr), .oRamWe(oRamWe), .oRamWData(oRamWData),
    .iRamRData(ramRData)
  );

  always #5 Clock = ~Clock;

  // Behavioural VRAM (read-first, one-cycle read latency) and write log.
  logic [DATA_W-1:0]        vram [1024];
  logic [ADDR_W+DATA_W-1:0] wrLog [$];

  always @(posedge Clock) begin
    if (oRamWe === 1'b1) wrLog.push_back({oRamAddr, oRamWData});
    if (Reset) begin
      for (int i = 0; i < 1024; i++) vram[i] <= '0;
      vram[10'h010] <= 3'b101;
      vram[10'h011] <= 3'b010;
      vram[10'h012] <= 3'b011;
    end else if (oRamWe === 1'b1) begin
      vram[oRamAddr[9:0]] <= oRamWData;
    end
    ramRData <= vram[oRamAddr[9:0]];
  end

  typedef struct {
    logic              rst;
    logic              rd;
    logic [ADDR_W-1:0] rdAddr;
    logic              wv;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              eWe;
    logic [ADDR_W-1:0] eAddr;
    logic [DATA_W-1:0] eWd;
    logic              eRdy;
    logic [LVL_W-1:0]  eLvl;
    logic              eRdv;
    logic [DATA_W-1:0] eRdData;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  function automatic vec_t mk(
    input logic rst, input logic rd, input logic [ADDR_W-1:0] ra,
    input logic wv, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
    input logic eWe, input logic [ADDR_W-1:0] eAddr, input logic [DATA_W-1:0] eWd,
    input logic eRdy, input logic [LVL_W-1:0] eLvl, input logic eRdv,
    input logic [DATA_W-1:0] eRdData);
    vec_t v;
    v.rst = rst; v.rd = rd; v.rdAddr = ra; v.wv = wv; v.wa = wa; v.wd = wd;
    v.eWe = eWe; v.eAddr = eAddr; v.eWd = eWd; v.eRdy = eRdy; v.eLvl = eLvl;
    v.eRdv = eRdv; v.eRdData = eRdData;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample outputs 1ns after the edge.
  task automatic cyc(input logic rst, input logic rd, input logic [ADDR_W-1:0] ra,
                     input logic wv, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
    Reset = rst; iRdReq = rd; iRdAddr = ra; iWrValid = wv; iWrAddr = wa; iWrData = wd;
    @(posedge Clock);
    #1;
    $display("t=%0t rst=%0b rd=%0b ra=%h wv=%0b wa=%h wd=%b | we=%0b addr=%h wdat=%b rdy=%0b lvl=%0d rdv=%0b rdd=%b",
             $time, rst, rd, ra, wv, wa, wd, oRamWe, oRamAddr, oRamWData, oWrReady, oWrLevel, oRdValid, oRdData);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r1;
    int   pushed;
    int   n;
    r1 = (CAP > 1);

    // rst rd  rdAddr   wv  wa       wd      | we  addr     wdat    rdy   lvl rdv rdData
    vecs[0]  = mk(1, 0, 16'h0000, 0, 16'h0000, 3'b000, 0, 16'h0000, 3'b000, 1,  0, 0, 3'b000);
    vecs[1]  = mk(0, 0, 16'h0000, 0, 16'h0000, 3'b000, 0, 16'h0000, 3'b000, 1,  0, 0, 3'b000);
    vecs[2]  = mk(0, 1, 16'h0010, 0, 16'h0000, 3'b000, 0, 16'h0010, 3'b000, 1,  0, 0, 3'b000);
    vecs[3]  = mk(0, 0, 16'h0000, 0, 16'h0000, 3'b000, 0, 16'h0010, 3'b000, 1,  0, 1, 3'b101);
    vecs[4]  = mk(0, 0, 16'h0000, 0, 16'h0000, 3'b000, 0, 16'h0010, 3'b000, 1,  0, 0, 3'b000);
    vecs[5]  = mk(0, 0, 16'h0000, 1, 16'h0100, 3'b111, 0, 16'h0010, 3'b000, r1, 1, 0, 3'b000);
    vecs[6]  = mk(0, 0, 16'h0000, 0, 16'h0000, 3'b000, 1, 16'h0100, 3'b111, 1,  0, 0, 3'b000);
    vecs[7]  = mk(0, 0, 16'h0000, 0, 16'h0000, 3'b000, 0, 16'h0100, 3'b111, 1,  0, 0, 3'b000);
    vecs[8]  = mk(0, 1, 16'h0010, 0, 16'h0000, 3'b000, 0, 16'h0010, 3'b111, 1,  0, 0, 3'b000);
    vecs[9]  = mk(0, 1, 16'h0011, 0, 16'h0000, 3'b000, 0, 16'h0011, 3'b111, 1,  0, 1, 3'b101);
    vecs[10] = mk(0, 1, 16'h0012, 0, 16'h0000, 3'b000, 0, 16'h0012, 3'b111, 1,  0, 1, 3'b010);
    vecs[11] = mk(0, 0, 16'h0000, 0, 16'h0000, 3'b000, 0, 16'h0012, 3'b111, 1,  0, 1, 3'b011);
    vecs[12] = mk(0, 0, 16'h0000, 0, 16'h0000, 3'b000, 0, 16'h0012, 3'b111, 1,  0, 0, 3'b000);
    vecs[13] = mk(0, 1, 16'h0030, 1, 16'h0200, 3'b001, 0, 16'h0030, 3'b111, r1, 1, 0, 3'b000);
    vecs[14] = mk(0, 1, 16'h0031, 0, 16'h0000, 3'b000, 0, 16'h0031, 3'b111, r1, 1, 1, 3'b000);
    vecs[15] = mk(0, 0, 16'h0000, 0, 16'h0000, 3'b000, 1, 16'h0200, 3'b001, 1,  0, 1, 3'b000);
    vecs[16] = mk(0, 0, 16'h0000, 0, 16'h0000, 3'b000, 0, 16'h0200, 3'b001, 1,  0, 0, 3'b000);
    vecs[17] = mk(0, 1, 16'h0010, 0, 16'h0000, 3'b000, 0, 16'h0010, 3'b001, 1,  0, 0, 3'b000);
    vecs[18] = mk(1, 1, 16'h0011, 0, 16'h0000, 3'b000, 0, 16'h0000, 3'b000, 1,  0, 0, 3'b000);
    vecs[19] = mk(0, 0, 16'h0000, 0, 16'h0000, 3'b000, 0, 16'h0000, 3'b000, 1,  0, 0, 3'b000);
    vecs[20] = mk(0, 0, 16'h0000, 0, 16'h0000, 3'b000, 0, 16'h0000, 3'b000, 1,  0, 0, 3'b000);

    for (int i = 0; i < NVEC; i++) begin
      cyc(vecs[i].rst, vecs[i].rd, vecs[i].rdAddr, vecs[i].wv, vecs[i].wa, vecs[i].wd);
      chk($sformatf("vec%0d_we", i),    32'(oRamWe),    32'(vecs[i].eWe));
      chk($sformatf("vec%0d_addr", i),  32'(oRamAddr),  32'(vecs[i].eAddr));
      chk($sformatf("vec%0d_wdata", i), 32'(oRamWData), 32'(vecs[i].eWd));
      chk($sformatf("vec%0d_ready", i), 32'(oWrReady),  32'(vecs[i].eRdy));
      chk($sformatf("vec%0d_level", i), 32'(oWrLevel),  32'(vecs[i].eLvl));
      chk($sformatf("vec%0d_rdvalid", i), 32'(oRdValid), 32'(vecs[i].eRdv));
      if (vecs[i].eRdv) chk($sformatf("vec%0d_rddata", i), 32'(oRdData), 32'(vecs[i].eRdData));
    end

    // Hazard: a queued write does not forward into a read of the same address.
    cyc(1'b0, 1'b1, 16'h0020, 1'b1, 16'h0020, 3'b010);
    cyc(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b000);
    chk("hazard_old_valid", 32'(oRdValid), 32'd1);
    chk("hazard_old_data",  32'(oRdData),  32'd0);
    chk("hazard_drain_we",  32'(oRamWe),   32'd1);
    idle();
    cyc(1'b0, 1'b1, 16'h0020, 1'b0, 16'h0000, 3'b000);
    idle();
    chk("hazard_new_valid", 32'(oRdValid), 32'd1);
    chk("hazard_new_data",  32'(oRdData),  32'd2);
    idle();

`ifdef VRAM_WRFIFO_EN
    // Priority: three writes queued under a continuous scan read.
    wrLog.delete();
    for (int i = 0; i < 10; i++)
      cyc(1'b0, 1'b1, 16'h0040, (i < 3), 16'(16'h0300 + i), 3'(i + 1));
    chk("prio_no_we",   32'(oRamWe),       32'd0);
    chk("prio_log",     32'(wrLog.size()), 32'd0);
    chk("prio_level",   32'(oWrLevel),     32'd3);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk($sformatf("prio_we%0d", i),   32'(oRamWe),    32'd1);
      chk($sformatf("prio_addr%0d", i), 32'(oRamAddr),  32'(16'h0300 + i));
      chk($sformatf("prio_data%0d", i), 32'(oRamWData), 32'(i + 1));
    end
    idle();
    chk("prio_done_level", 32'(oWrLevel), 32'd0);
    chk("prio_done_we",    32'(oRamWe),   32'd0);

    // Full: five writes offered with handshaking while the scan holds the port.
    wrLog.delete();
    pushed = 0;
    for (int i = 0; i < 8; i++) begin
      logic acc;
      acc = (pushed < 5) && oWrReady;
      cyc(1'b0, 1'b1, 16'h0050, (pushed < 5), 16'(16'h0380 + pushed), 3'(pushed + 1));
      if (acc) pushed++;
    end
    chk("full_pushed", 32'(pushed),   32'd4);
    chk("full_ready",  32'(oWrReady), 32'd0);
    chk("full_level",  32'(oWrLevel), 32'd4);
    // oWrReady is registered, so the held 5th entry goes in on the edge after
    // the first pop frees a slot: level 4 -> 3 (pop) -> 3 (pop+push).
    n = 0;
    while (wrLog.size() < 5 && n < 20) begin
      logic acc;
      acc = (pushed < 5) && oWrReady;
      cyc(1'b0, 1'b0, 16'h0000, (pushed < 5), 16'(16'h0380 + pushed), 3'(pushed + 1));
      if (acc) pushed++;
      if (n == 0) begin
        chk("full_pop1_level", 32'(oWrLevel), 32'd3);
        chk("full_pop1_ready", 32'(oWrReady), 32'd1);
      end
      if (n == 1) begin
        chk("full_pop2_level",  32'(oWrLevel), 32'd3);
        chk("full_pop2_pushed", 32'(pushed),   32'd5);
      end
      n++;
    end
    chk("full_retired", 32'(wrLog.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < wrLog.size())
        chk($sformatf("full_order%0d", i), 32'(wrLog[i]), 32'({16'(16'h0380 + i), 3'(i + 1)}));
    idle();
    chk("full_empty", 32'(oWrLevel), 32'd0);

    // Reset during drain: only the entry already committed reaches the RAM.
    wrLog.delete();
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b1, 16'h0060, 1'b1, 16'(16'h0390 + i), 3'(i + 4));
    chk("rstd_level4", 32'(oWrLevel), 32'd4);
    idle();
    chk("rstd_first_we",   32'(oRamWe),   32'd1);
    chk("rstd_first_addr", 32'(oRamAddr), 32'h0390);
    cyc(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b000);
    chk("rstd_we",    32'(oRamWe),   32'd0);
    chk("rstd_level", 32'(oWrLevel), 32'd0);
    chk("rstd_ready", 32'(oWrReady), 32'd1);
    for (int i = 0; i < 6; i++) idle();
    chk("rstd_log", 32'(wrLog.size()), 32'd1);
`else
    // Holding register: ready drops while occupied; a second write waits.
    wrLog.delete();
    cyc(1'b0, 1'b1, 16'h0040, 1'b1, 16'h0300, 3'b001);
    chk("hold_ready0", 32'(oWrReady), 32'd0);
    chk("hold_level1", 32'(oWrLevel), 32'd1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 16'h0040, 1'b1, 16'h0301, 3'b010);
    chk("hold_still_level", 32'(oWrLevel), 32'd1);
    chk("hold_no_we",       32'(oRamWe),   32'd0);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0301, 3'b010);
    chk("hold_pop_we",    32'(oRamWe),   32'd1);
    chk("hold_pop_addr",  32'(oRamAddr), 32'h0300);
    chk("hold_pop_level", 32'(oWrLevel), 32'd0);
    chk("hold_pop_ready", 32'(oWrReady), 32'd1);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0301, 3'b010);
    chk("hold_push2_level", 32'(oWrLevel), 32'd1);
    chk("hold_push2_we",    32'(oRamWe),   32'd0);
    idle();
    chk("hold_pop2_we",   32'(oRamWe),    32'd1);
    chk("hold_pop2_addr", 32'(oRamAddr),  32'h0301);
    chk("hold_pop2_data", 32'(oRamWData), 32'd2);
    idle();
    chk("hold_log", 32'(wrLog.size()), 32'd2);

    // Reset while the register is occupied discards the entry.
    wrLog.delete();
    cyc(1'b0, 1'b1, 16'h0040, 1'b1, 16'h0390, 3'b110);
    cyc(1'b1, 1'b1, 16'h0040, 1'b0, 16'h0000, 3'b000);
    chk("hrst_level", 32'(oWrLevel), 32'd0);
    chk("hrst_ready", 32'(oWrReady), 32'd1);
    for (int i = 0; i < 4; i++) idle();
    chk("hrst_log", 32'(wrLog.size()), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
